// File: rtl/usqrt_pkg.sv
// Shared constants and helpers for the multi-channel stochastic square-root array.
package usqrt_pkg;

  localparam int unsigned CH_DEF     = 4;
  localparam int unsigned DEP_DEF    = 4;
  localparam int unsigned DEPLOG_DEF = 2;
  localparam int unsigned WINLOG_DEF = 8;

  // Bit offset of a channel's history index inside the flat rand_num bus.
  function automatic int unsigned rand_off(input int unsigned ch, input int unsigned deplog);
    return ch * deplog;
  endfunction

  // One extra bit so a window of all ones (2^WINLOG) fits.
  function automatic int unsigned acc_w(input int unsigned winlog);
    return winlog + 1;
  endfunction

endpackage

// File: rtl/cordiv_core.sv
// One channel of the CORDIV square-root loop: toggle, registered trace and q history.
module cordiv_core
  import usqrt_pkg::*;
#(
  parameter int unsigned DEP    = DEP_DEF,
  parameter int unsigned DEPLOG = DEPLOG_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DEPLOG-1:0] rand_idx,
  input  logic              in,
  output logic              out
);

  logic           tog;
  logic           trace;
  logic [DEP-1:0] sr;
  logic           act;
  logic           dividend;
  logic           divisor;
  logic           q;

  // Feedback comes only from the registered trace, so in never loops back to out.
  always_comb begin
    act      = en & ~rst;
    out      = act & (trace | in);
    dividend = ~tog & out;
    divisor  = tog | dividend;
    q        = divisor ? dividend : sr[rand_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tog   <= 1'b0;
      trace <= 1'b0;
      sr    <= '0;
    end else if (act) begin
      tog   <= ~tog;
      trace <= q;
      sr    <= {sr[DEP-2:0], q};
    end
  end

endmodule

// File: rtl/usqrt_cordiv_array.sv
// CH independent stochastic square-root channels; define USQRT_ACC_EN to add
// the per-channel windowed ones-counter (otherwise acc/acc_vld are tied to 0).
module usqrt_cordiv_array
  import usqrt_pkg::*;
#(
  parameter int unsigned CH     = CH_DEF,
  parameter int unsigned DEP    = DEP_DEF,
  parameter int unsigned DEPLOG = DEPLOG_DEF,
  parameter int unsigned WINLOG = WINLOG_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CH-1:0]            en,
  input  logic [CH*DEPLOG-1:0]     rand_num,
  input  logic [CH-1:0]            in,
  output logic [CH-1:0]            out,
  output logic [CH*(WINLOG+1)-1:0] acc,
  output logic [CH-1:0]            acc_vld
);

  localparam int unsigned AW = acc_w(WINLOG);

  for (genvar c = 0; c < int'(CH); c++) begin : g_ch
    cordiv_core #(
      .DEP    (DEP),
      .DEPLOG (DEPLOG)
    ) u_core (
      .clk      (clk),
      .rst      (rst),
      .en       (en[c]),
      .rand_idx (rand_num[rand_off(c, DEPLOG) +: DEPLOG]),
      .in       (in[c]),
      .out      (out[c])
    );

`ifdef USQRT_ACC_EN
    logic [WINLOG-1:0] win_cnt;
    logic [AW-1:0]     ones;
    logic [AW-1:0]     acc_r;
    logic              vld_r;
    logic              act;

    always_comb act = en[c] & ~rst;

    // The closing cycle's own out bit is folded into acc, not into ones.
    always_ff @(posedge clk) begin
      if (rst) begin
        win_cnt <= '0;
        ones    <= '0;
        acc_r   <= '0;
        vld_r   <= 1'b0;
      end else begin
        vld_r <= 1'b0;
        if (act) begin
          win_cnt <= win_cnt + 1'b1;
          if (win_cnt == '1) begin
            acc_r <= ones + AW'(out[c]);
            ones  <= '0;
            vld_r <= 1'b1;
          end else begin
            ones <= ones + AW'(out[c]);
          end
        end
      end
    end

    always_comb begin
      acc[c*AW +: AW] = acc_r;
      acc_vld[c]      = vld_r;
    end
`else
    always_comb begin
      acc[c*AW +: AW] = '0;
      acc_vld[c]      = 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_usqrt_cordiv_array.sv
// Self-checking bench for usqrt_cordiv_array: hand table plus randomized runs
// against a history-queue reference model; honours USQRT_ACC_EN.
`timescale 1ns/1ps
module tb_usqrt_cordiv_array;

  localparam int CH     = 4;
  localparam int DEP    = 4;
  localparam int DEPLOG = 2;
  localparam int WINLOG = 8;
  localparam int AW     = WINLOG + 1;
  localparam int WIN    = 1 << WINLOG;
  localparam int RW     = CH * DEPLOG;

  typedef struct {
    logic              en;
    logic              in;
    logic [DEPLOG-1:0] rnd;
    logic              exp_out;
  } vec_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [CH-1:0]        en;
  logic [RW-1:0]        rand_num;
  logic [CH-1:0]        in;
  logic [CH-1:0]        out;
  logic [CH*AW-1:0]     acc;
  logic [CH-1:0]        acc_vld;

  int checks = 0;
  int errors = 0;

  // reference model: enabled-cycle count (parity), last q, q history newest-first
  int m_cnt   [CH];
  bit m_trace [CH];
  bit m_hist  [CH][$];
  int m_ones  [CH];
  int m_acc   [CH];
  bit m_vld   [CH];

  logic [CH-1:0] obs_out;
  int            dut_ones [CH];

  always #5 clk = ~clk;

  usqrt_cordiv_array #(
    .CH     (CH),
    .DEP    (DEP),
    .DEPLOG (DEPLOG),
    .WINLOG (WINLOG)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .rand_num (rand_num),
    .in       (in),
    .out      (out),
    .acc      (acc),
    .acc_vld  (acc_vld)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_cnt[c] = 0; m_trace[c] = 0; m_hist[c].delete();
      m_ones[c] = 0; m_acc[c] = 0; m_vld[c] = 0;
    end
  endtask

  task automatic clear_counts();
    for (int c = 0; c < CH; c++) dut_ones[c] = 0;
  endtask

  // One clock: drive, check outputs against the model, then advance the model.
  task automatic step(input logic r, input logic [CH-1:0] e, input logic [CH-1:0] i,
                      input logic [RW-1:0] rn);
    logic [CH-1:0]    eo;
    logic [CH*AW-1:0] ea;
    logic [CH-1:0]    ev;
    bit               o, q, past;
    int               idx;
    @(negedge clk);
    rst = r; en = e; in = i; rand_num = rn;
    #1;
    eo = '0; ea = '0; ev = '0;
    for (int c = 0; c < CH; c++) begin
      eo[c] = e[c] && !r && (m_trace[c] || i[c]);
`ifdef USQRT_ACC_EN
      ea[c*AW +: AW] = AW'(m_acc[c]);
      ev[c]          = m_vld[c];
`endif
    end
    obs_out = out;
    for (int c = 0; c < CH; c++) dut_ones[c] += int'(out[c]);
    chk("out", out, eo);
    chk("acc", acc, ea);
    chk("acc_vld", acc_vld, ev);
    if (r) begin
      model_reset();
    end else begin
      for (int c = 0; c < CH; c++) begin
        if (e[c]) begin
          o   = eo[c];
          idx = int'(rn[c*DEPLOG +: DEPLOG]);
          past = (idx < m_hist[c].size()) ? m_hist[c][idx] : 1'b0;
          // even enabled cycles pass out (or a random past q when out=0); odd cycles yield 0
          q = (m_cnt[c] % 2 == 1) ? 1'b0 : (o ? 1'b1 : past);
          m_trace[c] = q;
          m_hist[c].push_front(q);
          if (m_hist[c].size() > DEP) void'(m_hist[c].pop_back());
          if (m_cnt[c] % WIN == WIN - 1) begin
            m_acc[c] = m_ones[c] + int'(o); m_ones[c] = 0; m_vld[c] = 1;
          end else begin
            m_ones[c] += int'(o); m_vld[c] = 0;
          end
          m_cnt[c]++;
        end else begin
          m_vld[c] = 0;
        end
      end
    end
  endtask

  function automatic logic [CH-1:0] rbits(input int pct);
    logic [CH-1:0] b;
    for (int c = 0; c < CH; c++) b[c] = ($urandom_range(99) < pct);
    return b;
  endfunction

  vec_t tbl[13];

  initial begin
    int first0, first1, first, nvld, off1;

    tbl[0]  = '{1'b1, 1'b1, 2'd0, 1'b1};
    tbl[1]  = '{1'b1, 1'b0, 2'd0, 1'b1};
    tbl[2]  = '{1'b1, 1'b0, 2'd0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 2'd0, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 2'd0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 2'd0, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 2'd0, 1'b1};
    tbl[7]  = '{1'b1, 1'b1, 2'd0, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 2'd0, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 2'd1, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 2'd0, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 2'd3, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 2'd0, 1'b1};

    model_reset();
    clear_counts();
    rst = 1'b1; en = '0; in = '0; rand_num = '0;
    @(posedge clk);
    @(posedge clk);

    // reset held with en=1, in=1: out must stay 0 and acc/acc_vld at 0
    step(1'b1, '1, '1, '0);
    chk("reset_out", obs_out, '0);

    // hand-derived sequence, identical on every channel
    for (int k = 0; k < 13; k++) begin
      step(1'b0, {CH{tbl[k].en}}, {CH{tbl[k].in}}, {CH{tbl[k].rnd}});
      chk("tbl_out", obs_out, {CH{tbl[k].exp_out}});
    end

    // in=0 for 1000 cycles
    step(1'b1, '1, '0, '0);
    clear_counts();
    nvld = 0;
    for (int k = 0; k < 1000; k++) begin
      step(1'b0, '1, '0, RW'($urandom));
      if (acc_vld[0]) begin
        nvld++;
        chk("acc_zero", acc[AW-1:0], 0);
      end
    end
    chk("zero_ones_ch0", dut_ones[0], 0);
    chk("zero_ones_ch3", dut_ones[3], 0);
`ifdef USQRT_ACC_EN
    chk("zero_vld_count", nvld, 3);
`else
    chk("zero_vld_count", nvld, 0);
`endif

    // in=1 constant: out=1 every enabled cycle, full windows
    step(1'b1, '1, '0, '0);
    clear_counts();
    for (int k = 0; k < 600; k++) begin
      step(1'b0, '1, '1, RW'($urandom));
      if (acc_vld[2]) chk("acc_full", acc[2*AW +: AW], WIN);
    end
    chk("full_ones_ch0", dut_ones[0], 600);
    chk("full_ones_ch2", dut_ones[2], 600);

    // random streams at two densities, every cycle checked against the model
    for (int pass = 0; pass < 2; pass++) begin
      step(1'b1, '1, '0, '0);
      for (int k = 0; k < 4096; k++)
        step(1'b0, '1, rbits(pass == 0 ? 25 : 64), RW'($urandom));
    end

    // reset in the middle of a window
    for (int k = 0; k < 100; k++) step(1'b0, '1, '1, RW'($urandom));
    step(1'b1, '1, '1, RW'($urandom));
    step(1'b0, '1, '0, '0);
    chk("post_rst_out", obs_out, '0);
    first = -1;
    for (int k = 2; k <= 300; k++) begin
      step(1'b0, '1, rbits(50), RW'($urandom));
      if (acc_vld[0] && first < 0) first = k;
    end
`ifdef USQRT_ACC_EN
    chk("rst_vld_latency", first, WIN + 1);
`else
    chk("rst_vld_latency", first, -1);
`endif

    // channel 1 disabled for 100 cycles inside its window
    step(1'b1, '1, '0, '0);
    first0 = -1; first1 = -1;
    for (int k = 1; k <= 450; k++) begin
      logic [CH-1:0] e;
      e = '1;
      if (k > 50 && k <= 150) e[1] = 1'b0;
      off1 = dut_ones[1];
      step(1'b0, e, rbits(50), RW'($urandom));
      if (!e[1]) chk("ch1_off_out", dut_ones[1] - off1, 0);
      if (acc_vld[0] && first0 < 0) first0 = k;
      if (acc_vld[1] && first1 < 0) first1 = k;
    end
`ifdef USQRT_ACC_EN
    chk("ch1_window_delay", first1 - first0, 100);
`else
    chk("ch1_window_delay", first1 - first0, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
